i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//  I2C target (slave) responder: answers a bus controller on SCL/SDA, matches a 7-bit address,
//  exposes a byte-wide register port (pointer byte, then auto-incrementing data bytes).
//  Sits beside the controller block; shares the open-drain SDA wire, never drives SCL (no stretching).
// PARAMETERS
//  DEV_ADDR  7'h50  7-bit target address matched after START
//  AW        8      register pointer width (pointer byte's low AW bits used; wraps at 2**AW)
// PORTS
//  clk        in   1   system clock; SCL high and low phases each >= 4 clk
//  rst        in   1   synchronous, active-low reset
//  scl_i      in   1   bus SCL (asynchronous, synchronised internally)
//  sda_i      in   1   bus SDA (asynchronous, synchronised internally)
//  sda_oe     out  1   1 = pull SDA low; 0 = release (open-drain, pad drives 0 only)
//  reg_addr   out  AW  current register pointer
//  reg_wdata  out  8   write data, valid with reg_we
//  reg_we     out  1   1-clk write strobe
//  reg_rdata  in   8   read data for reg_addr; valid <= 1 clk after reg_addr changes
//  busy       out  1   1 from address match to STOP/mismatch
//  done       out  1   1-clk pulse on STOP ending a transaction that matched DEV_ADDR
// BEHAVIOUR
//  Reset (rst=0 at clk edge): sda_oe=0, reg_we=0, busy=0, done=0, reg_addr=0, state IDLE.
//  Reset mid-transfer abandons it; SDA released same clk; no write issued.
//  Inputs: 2-flop sync, then 1-clk edge detect -> scl_rise, scl_fall, start, stop (3 clk input latency).
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. SDA sampled on scl_rise.
//  sda_oe changes only on scl_fall (or on STOP/reset, which release it).
//  States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//  IDLE   -start-> ADDR. All states: start -> ADDR (repeated START, pointer retained);
//         stop -> IDLE (sda_oe=0; done pulses if busy was 1).
//  ADDR   shift 8 bits MSB first. {addr,rw} on 8th rise. Match -> ADDR_ACK, busy=1; else IGNORE.
//  ADDR_ACK  drive ACK (sda_oe=1) from the scl_fall after bit 8 to the next scl_fall.
//         rw=0 -> PTR. rw=1 -> RDATA; shift reg loaded with reg_rdata on that ending scl_fall.
//  PTR    8 bits -> reg_addr <= byte[AW-1:0]; PTR_ACK drives ACK -> WDATA.
//  WDATA  8 bits; on the scl_fall after bit 8: reg_wdata=byte, reg_we=1 for 1 clk, ACK driven.
//         Next clk reg_addr += 1 (mod 2**AW). WDATA_ACK -> WDATA.
//  RDATA  sda_oe = ~shift[7] per bit, updated on scl_fall. On the scl_fall after bit 8:
//         release SDA, reg_addr += 1. RDATA_ACK samples controller bit on rise.
//         ACK(0) -> reload shift from reg_rdata on next scl_fall -> RDATA; NACK(1) -> IGNORE.
//  IGNORE sda_oe=0, wait for start/stop. busy=0 unless entered by read NACK.
//  Bit counter 3 bits, cleared on start and on each ACK phase. start and stop in the same clk cannot occur.
//  No general call, 10-bit addressing or clock stretching. Write with no data bytes only updates the pointer.
// STRUCTURE
//  Package i2c_pkg: state enum, I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_ADDR_W=7.
//  Sub-module i2c_bus_sync: synchronisers, edge detect; outputs scl_rise/scl_fall/start/stop/sda_s.
//  Top holds the FSM, shift register, bit counter and pointer.
// TESTING (bench models the controller: SCL period 40 clk, pull-up = AND of both drivers)
//  1 Write 0xA0 (0x50,W), ptr 0x10, data 0x3C,0x5A, STOP -> ACK on 4 bytes; reg_we at 0x10=0x3C, 0x11=0x5A; done once.
//  2 Write ptr 0x20, Sr, 0xA1, read 3 bytes (ACK,ACK,NACK), STOP -> bytes = model regs 0x20..0x22; SDA released after NACK.
//  3 Address 0x51 -> no ACK (SDA high on 9th clock), no reg_we, busy stays 0, no done.
//  4 AW=8, ptr 0xFF, write 2 bytes -> writes at 0xFF then 0x00 (wrap).
//  5 STOP after bit 4 of a data byte -> no reg_we, IDLE, sda_oe=0; next transaction normal.
//  6 rst=0 during ACK drive -> sda_oe=0 next clk, all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target register port
package i2c_pkg;

    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;
    localparam int   I2C_ADDR_W = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronisers and bus event detection
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    // [0],[1] form the two-flop synchroniser, [2] holds the previous synchronised value
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Synchronise both lines (reset to the idle-high bus level) and register single-clk events
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_q    <= 3'b111;
            sda_q    <= 3'b111;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda_s    <= 1'b1;
        end else begin
            scl_q    <= {scl_q[1:0], scl_i};
            sda_q    <= {sda_q[1:0], sda_i};
            scl_rise <= scl_q[1] & ~scl_q[2];
            scl_fall <= ~scl_q[1] & scl_q[2];
            start    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
            stop     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
            sda_s    <= sda_q[1];
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with pointer byte and auto-incrementing register port
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h50,
    parameter int                    AW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          done
);

    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;
    logic       sda_s;

    state_t     state;
    logic [7:0] shift;
    logic [2:0] cnt;
    logic       rw;
    logic       ack_phase;   // 0: ACK slot not yet opened, 1: ACK slot in progress
    logic [7:0] byte_in;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    // Byte as it will look once the bit sampled on this rise is shifted in
    assign byte_in = {shift[6:0], sda_s};

    // Protocol FSM: samples SDA on SCL rise, changes SDA drive only on SCL fall, STOP or reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shift     <= 8'h00;
            cnt       <= 3'd0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            done   <= 1'b0;
            // Pointer advances the clock after each write strobe
            if (reg_we) begin
                reg_addr <= reg_addr + 1'b1;
            end

            if (start) begin
                state     <= ST_ADDR;
                cnt       <= 3'd0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (stop) begin
                state     <= ST_IDLE;
                cnt       <= 3'd0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                done      <= busy;
                busy      <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        shift <= byte_in;
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt       <= 3'd0;
                            ack_phase <= 1'b0;
                            case (state)
                                ST_ADDR: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        busy  <= 1'b1;
                                        rw    <= byte_in[0];
                                        state <= ST_ADDR_ACK;
                                    end else begin
                                        busy  <= 1'b0;
                                        state <= ST_IGNORE;
                                    end
                                end
                                ST_PTR: begin
                                    reg_addr <= byte_in[AW-1:0];
                                    state    <= ST_PTR_ACK;
                                end
                                default: begin
                                    state <= ST_WDATA_ACK;
                                end
                            endcase
                        end
                    end
                    ST_RDATA: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt       <= 3'd0;
                            ack_phase <= 1'b0;
                            state     <= ST_RDATA_ACK;
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (sda_s == I2C_NACK) begin
                            ack_phase <= 1'b0;
                            state     <= ST_IGNORE;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (scl_fall) begin
                case (state)
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                            if (state == ST_WDATA_ACK) begin
                                reg_wdata <= shift;
                                reg_we    <= 1'b1;
                            end
                        end else begin
                            ack_phase <= 1'b0;
                            cnt       <= 3'd0;
                            if (state == ST_ADDR_ACK && rw) begin
                                shift  <= reg_rdata;
                                sda_oe <= ~reg_rdata[7];
                                state  <= ST_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        sda_oe <= ~shift[6];
                        shift  <= {shift[6:0], 1'b0};
                    end
                    ST_RDATA_ACK: begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b0;
                            ack_phase <= 1'b1;
                            reg_addr  <= reg_addr + 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            shift     <= reg_rdata;
                            sda_oe    <= ~reg_rdata[7];
                            state     <= ST_RDATA;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed controller-model bench for i2c_target_regs
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv;
    logic       sda_drv;
    wire        sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:255];
    logic [7:0] wa_q [$];
    logic [7:0] wd_q [$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    assign sda_bus   = sda_drv & ~sda_oe;
    assign reg_rdata = mem[reg_addr];

    i2c_target_regs #(.DEV_ADDR(7'h50), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_drv),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (reg_we) begin
            wa_q.push_back(reg_addr);
            wd_q.push_back(reg_wdata);
            mem[reg_addr] <= reg_wdata;
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1;
        wait_clk(10);
        scl_drv = 1'b1;
        wait_clk(10);
        sda_drv = 1'b0;
        wait_clk(10);
        scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(10);
        sda_drv = 1'b0;
        wait_clk(10);
        scl_drv = 1'b1;
        wait_clk(10);
        sda_drv = 1'b1;
        wait_clk(20);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        wait_clk(10);
        sda_drv = b;
        wait_clk(10);
        scl_drv = 1'b1;
        wait_clk(10);
        s = sda_bus;
        wait_clk(10);
        scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_in, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d = {d[6:0], s};
        end
        bus_bit(ack_in, s);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        wait_clk(5);
        checks += 5;
        if (sda_oe !== 1'b0)   begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        if (reg_we !== 1'b0)   begin errors++; $display("FAIL reset_reg_we got=%b exp=0", reg_we); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (reg_addr !== 8'h0) begin errors++; $display("FAIL reset_reg_addr got=%h exp=00", reg_addr); end
        rst = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_write();
        logic [7:0] bytes [4];
        logic       ack;
        int         n0 = wa_q.size();
        int         d0 = done_cnt;
        bytes = '{8'hA0, 8'h10, 8'h3C, 8'h5A};
        bus_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b0) begin errors++; $display("FAIL write_ack%0d got=%b exp=0", i, ack); end
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got=%b exp=1", busy); end
        bus_stop();
        checks++;
        if (wa_q.size() != n0 + 2) begin
            errors++; $display("FAIL write_count got=%0d exp=%0d", wa_q.size() - n0, 2);
        end else begin
            checks += 4;
            if (wa_q[n0] !== 8'h10)   begin errors++; $display("FAIL write_addr0 got=%h exp=10", wa_q[n0]); end
            if (wd_q[n0] !== 8'h3C)   begin errors++; $display("FAIL write_data0 got=%h exp=3c", wd_q[n0]); end
            if (wa_q[n0+1] !== 8'h11) begin errors++; $display("FAIL write_addr1 got=%h exp=11", wa_q[n0+1]); end
            if (wd_q[n0+1] !== 8'h5A) begin errors++; $display("FAIL write_data1 got=%h exp=5a", wd_q[n0+1]); end
        end
        checks += 3;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL write_done got=%0d exp=1", done_cnt - d0); end
        if (reg_addr !== 8'h12) begin errors++; $display("FAIL write_ptr_end got=%h exp=12", reg_addr); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL write_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp_d [3];
        int         d0 = done_cnt;
        exp_d = '{8'h7A, 8'h7B, 8'h78};
        bus_start();
        write_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_w_ack got=%b exp=0", ack); end
        write_byte(8'h20, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL read_ptr_ack got=%b exp=0", ack); end
        bus_start();
        write_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_r_ack got=%b exp=0", ack); end
        for (int i = 0; i < 3; i++) begin
            read_byte((i == 2) ? 1'b1 : 1'b0, d);
            checks++;
            if (d !== exp_d[i]) begin errors++; $display("FAIL read_byte%0d got=%h exp=%h", i, d, exp_d[i]); end
        end
        wait_clk(5);
        checks += 2;
        if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_release got=%b exp=0", sda_oe); end
        if (busy !== 1'b1)   begin errors++; $display("FAIL read_busy_nack got=%b exp=1", busy); end
        bus_stop();
        checks += 2;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL read_done got=%0d exp=1", done_cnt - d0); end
        if (reg_addr !== 8'h23) begin errors++; $display("FAIL read_ptr_end got=%h exp=23", reg_addr); end
    endtask

    task automatic test_bad_addr();
        logic ack;
        int   n0 = wa_q.size();
        int   d0 = done_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL bad_addr_ack got=%b exp=1", ack); end
        write_byte(8'h33, ack);
        checks += 2;
        if (ack !== 1'b1)  begin errors++; $display("FAIL bad_addr_data_ack got=%b exp=1", ack); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy got=%b exp=0", busy); end
        bus_stop();
        checks += 2;
        if (wa_q.size() != n0)  begin errors++; $display("FAIL bad_addr_we got=%0d exp=0", wa_q.size() - n0); end
        if (done_cnt != d0)     begin errors++; $display("FAIL bad_addr_done got=%0d exp=0", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        logic [7:0] bytes [4];
        logic       ack;
        int         n0 = wa_q.size();
        bytes = '{8'hA0, 8'hFF, 8'h11, 8'h22};
        bus_start();
        for (int i = 0; i < 4; i++) write_byte(bytes[i], ack);
        bus_stop();
        checks++;
        if (wa_q.size() != n0 + 2) begin
            errors++; $display("FAIL wrap_count got=%0d exp=2", wa_q.size() - n0);
        end else begin
            checks += 4;
            if (wa_q[n0] !== 8'hFF)   begin errors++; $display("FAIL wrap_addr0 got=%h exp=ff", wa_q[n0]); end
            if (wd_q[n0] !== 8'h11)   begin errors++; $display("FAIL wrap_data0 got=%h exp=11", wd_q[n0]); end
            if (wa_q[n0+1] !== 8'h00) begin errors++; $display("FAIL wrap_addr1 got=%h exp=00", wa_q[n0+1]); end
            if (wd_q[n0+1] !== 8'h22) begin errors++; $display("FAIL wrap_data1 got=%h exp=22", wd_q[n0+1]); end
        end
        checks++;
        if (reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr_end got=%h exp=01", reg_addr); end
    endtask

    task automatic test_abort();
        logic       ack;
        logic       s;
        logic [7:0] abort_byte = 8'h99;
        int         n0 = wa_q.size();
        int         d0 = done_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h30, ack);
        for (int i = 7; i >= 4; i--) bus_bit(abort_byte[i], s);
        bus_stop();
        checks += 4;
        if (wa_q.size() != n0)  begin errors++; $display("FAIL abort_we got=%0d exp=0", wa_q.size() - n0); end
        if (sda_oe !== 1'b0)    begin errors++; $display("FAIL abort_sda_oe got=%b exp=0", sda_oe); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_done got=%0d exp=1", done_cnt - d0); end
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h40, ack);
        write_byte(8'h77, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL abort_next_ack got=%b exp=0", ack); end
        bus_stop();
        checks++;
        if (wa_q.size() != n0 + 1) begin
            errors++; $display("FAIL abort_next_count got=%0d exp=1", wa_q.size() - n0);
        end else begin
            checks += 2;
            if (wa_q[n0] !== 8'h40) begin errors++; $display("FAIL abort_next_addr got=%h exp=40", wa_q[n0]); end
            if (wd_q[n0] !== 8'h77) begin errors++; $display("FAIL abort_next_data got=%h exp=77", wd_q[n0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic       s;
        logic       ack;
        logic [7:0] addr_byte = 8'hA0;
        int         n0;
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(addr_byte[i], s);
        wait_clk(8);
        checks++;
        if (sda_oe !== 1'b1) begin errors++; $display("FAIL mid_ack_drive got=%b exp=1", sda_oe); end
        rst = 1'b0;
        wait_clk(1);
        checks += 5;
        if (sda_oe !== 1'b0)   begin errors++; $display("FAIL mid_sda_oe got=%b exp=0", sda_oe); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        if (reg_we !== 1'b0)   begin errors++; $display("FAIL mid_reg_we got=%b exp=0", reg_we); end
        if (done !== 1'b0)     begin errors++; $display("FAIL mid_done got=%b exp=0", done); end
        if (reg_addr !== 8'h0) begin errors++; $display("FAIL mid_reg_addr got=%h exp=00", reg_addr); end
        sda_drv = 1'b1;
        wait_clk(5);
        scl_drv = 1'b1;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(10);
        n0 = wa_q.size();
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h50, ack);
        write_byte(8'hEE, ack);
        bus_stop();
        checks++;
        if (wa_q.size() != n0 + 1) begin
            errors++; $display("FAIL mid_next_count got=%0d exp=1", wa_q.size() - n0);
        end else begin
            checks += 2;
            if (wa_q[n0] !== 8'h50) begin errors++; $display("FAIL mid_next_addr got=%h exp=50", wa_q[n0]); end
            if (wd_q[n0] !== 8'hEE) begin errors++; $display("FAIL mid_next_data got=%h exp=ee", wd_q[n0]); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
